// File: rtl/genius_input_checker.sv
// Checks a player's button presses against a stored symbol sequence for one round,
// reporting per-press success, round completion, and the reason for any failure.
module genius_input_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [4:0] round_len_i,
  input  logic       bt0_i,
  input  logic       bt1_i,
  input  logic       bt2_i,
  input  logic [1:0] seq_sym_i,
  output logic [3:0] seq_idx_o,
  output logic       busy_o,
  output logic       step_ok_o,
  output logic       round_ok_o,
  output logic       fail_o,
  output logic [1:0] fail_code_o,
  output logic [4:0] progress_o
);

  localparam int unsigned CntW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmMax + 1);

  localparam logic [1:0] CodeNone    = 2'b00;
  localparam logic [1:0] CodeWrong   = 2'b01;
  localparam logic [1:0] CodeTimeout = 2'b10;
  localparam logic [1:0] CodeBadLen  = 2'b11;

  typedef enum logic [1:0] {StIdle, StWaitPress, StWaitRelease} state_e;

  // Button synchronizer, all three buttons shifted together
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] btn_s;
  logic       any_s;
  logic [1:0] sym_s;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bt2_i, bt1_i, bt0_i};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];
  assign any_s = |btn_s;

  always_comb begin
    case (btn_s)
      3'b001:  sym_s = 2'd0;
      3'b010:  sym_s = 2'd1;
      3'b100:  sym_s = 2'd2;
      default: sym_s = 2'd3;
    endcase
  end

  // Edge detection is held off until the synchronizer has refilled after reset, so a
  // button held through reset release does not look like a fresh press.
  logic             any_q;
  logic [WarmW-1:0] warm_q;
  logic             press_q;
  logic [1:0]       sym_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      any_q   <= 1'b0;
      warm_q  <= '0;
      press_q <= 1'b0;
      sym_q   <= 2'd0;
    end else begin
      any_q   <= any_s;
      press_q <= any_s & ~any_q & (warm_q == WarmW'(WarmMax));
      sym_q   <= sym_s;
      if (warm_q != WarmW'(WarmMax)) warm_q <= warm_q + WarmW'(1);
    end
  end

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      prog_q, prog_d;
  logic [4:0]      len_q, len_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  logic            step_q, step_d;
  logic            rok_q, rok_d;
  logic            fail_q, fail_d;
  logic            len_legal;

  assign len_legal = (round_len_i != 5'd0) && (round_len_i <= 5'd16);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prog_d  = prog_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    step_d  = 1'b0;
    rok_d   = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_legal) begin
            state_d = StWaitPress;
            idx_d   = 4'd0;
            prog_d  = 5'd0;
            cnt_d   = '0;
            code_d  = CodeNone;
            len_d   = round_len_i;
          end else if (!fail_q) begin
            // Gated on fail_q so a held start cannot produce back-to-back fail pulses
            fail_d = 1'b1;
            code_d = CodeBadLen;
          end
        end
      end
      StWaitPress: begin
        if (press_q) begin
          if (sym_q == seq_sym_i) begin
            step_d = 1'b1;
            prog_d = prog_q + 5'd1;
            idx_d  = idx_q + 4'd1;
            cnt_d  = '0;
            if ((prog_q + 5'd1) == len_q) begin
              rok_d   = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StWaitRelease;
            end
          end else begin
            fail_d  = 1'b1;
            code_d  = CodeWrong;
            state_d = StIdle;
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          fail_d  = 1'b1;
          code_d  = CodeTimeout;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitRelease: begin
        if (!any_s) state_d = StWaitPress;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      prog_q  <= 5'd0;
      len_q   <= 5'd0;
      cnt_q   <= '0;
      code_q  <= CodeNone;
      step_q  <= 1'b0;
      rok_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prog_q  <= prog_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      step_q  <= step_d;
      rok_q   <= rok_d;
      fail_q  <= fail_d;
    end
  end

  assign seq_idx_o   = idx_q;
  assign busy_o      = (state_q != StIdle);
  assign step_ok_o   = step_q;
  assign round_ok_o  = rok_q;
  assign fail_o      = fail_q;
  assign fail_code_o = code_q;
  assign progress_o  = prog_q;

endmodule
